// File: rtl/accelerator_convolution_engine.sv
// Full 1-D convolution engine: single-cycle integer MAC, or IEEE float through handshake sub-units.
// The float sub-units take normal operands only and truncate; zero exponents are treated as zero.

module accelerator_scalar_float_multiplier #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [CONTROL_SIZE-1:0] OPERATION,
  input  logic [DATA_SIZE-1:0]    DATA_A_IN,
  input  logic [DATA_SIZE-1:0]    DATA_B_IN,
  output logic                    READY,
  output logic [DATA_SIZE-1:0]    DATA_OUT
);
  localparam int EW   = (DATA_SIZE == 32) ? 8 : 11;
  localparam int FW   = DATA_SIZE - 1 - EW;
  localparam int BIAS = (1 << (EW - 1)) - 1;

  logic [FW:0]          ma, mb;
  logic [2*FW+1:0]      p;
  logic [EW+1:0]        e_sum;
  logic [FW-1:0]        frac;
  logic [DATA_SIZE-1:0] res;
  logic                 sgn, zero;
  logic                 unused_bits;

  // A nonzero OPERATION negates the product.
  always_comb begin
    ma    = {1'b1, DATA_A_IN[FW-1:0]};
    mb    = {1'b1, DATA_B_IN[FW-1:0]};
    p     = ma * mb;
    sgn   = DATA_A_IN[DATA_SIZE-1] ^ DATA_B_IN[DATA_SIZE-1] ^ (|OPERATION);
    zero  = (DATA_A_IN[DATA_SIZE-2:FW] == '0) || (DATA_B_IN[DATA_SIZE-2:FW] == '0);
    e_sum = {2'b00, DATA_A_IN[DATA_SIZE-2:FW]} + {2'b00, DATA_B_IN[DATA_SIZE-2:FW]}
          - (EW+2)'(BIAS) + {{(EW+1){1'b0}}, p[2*FW+1]};
    frac  = p[2*FW+1] ? p[2*FW:FW+1] : p[2*FW-1:FW];
    res   = zero ? '0 : {sgn, e_sum[EW-1:0], frac};
  end

  assign unused_bits = ^{p[FW-1:0], e_sum[EW+1:EW]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      READY    <= 1'b0;
      DATA_OUT <= '0;
    end else begin
      READY <= START;
      if (START) DATA_OUT <= res;
    end
  end
endmodule

module accelerator_scalar_float_adder #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [CONTROL_SIZE-1:0] OPERATION,
  input  logic [DATA_SIZE-1:0]    DATA_A_IN,
  input  logic [DATA_SIZE-1:0]    DATA_B_IN,
  output logic                    READY,
  output logic [DATA_SIZE-1:0]    DATA_OUT
);
  localparam int EW = (DATA_SIZE == 32) ? 8 : 11;
  localparam int FW = DATA_SIZE - 1 - EW;

  logic [DATA_SIZE-1:0] b_eff, big, sml, res;
  logic [EW-1:0]        e_big, e_sml, e_dif, shift, exp_r;
  logic [FW+1:0]        m_big, m_sml, m_sh, sum, norm;
  logic [FW-1:0]        frac;
  logic                 swap, zero;
  logic                 unused_bits;

  // A nonzero OPERATION subtracts B; the larger magnitude sets the result sign.
  always_comb begin
    b_eff = {DATA_B_IN[DATA_SIZE-1] ^ (|OPERATION), DATA_B_IN[DATA_SIZE-2:0]};
    swap  = DATA_A_IN[DATA_SIZE-2:0] < b_eff[DATA_SIZE-2:0];
    big   = swap ? b_eff : DATA_A_IN;
    sml   = swap ? DATA_A_IN : b_eff;
    e_big = big[DATA_SIZE-2:FW];
    e_sml = sml[DATA_SIZE-2:FW];
    m_big = (e_big == '0) ? '0 : {2'b01, big[FW-1:0]};
    m_sml = (e_sml == '0) ? '0 : {2'b01, sml[FW-1:0]};
    e_dif = e_big - e_sml;
    m_sh  = (e_dif >= EW'(FW + 2)) ? '0 : m_sml >> e_dif;
    shift = '0;
    norm  = '0;
    zero  = 1'b0;
    sum   = '0;
    frac  = '0;
    exp_r = e_big;
    if (big[DATA_SIZE-1] == sml[DATA_SIZE-1]) begin
      sum = m_big + m_sh;
      if (sum[FW+1]) begin
        frac  = sum[FW:1];
        exp_r = e_big + EW'(1);
      end else begin
        frac  = sum[FW-1:0];
      end
    end else begin
      sum  = m_big - m_sh;
      zero = (sum == '0);
      for (int i = 0; i <= FW; i++) if (sum[i]) shift = EW'(FW - i);
      norm  = sum << shift;
      frac  = norm[FW-1:0];
      exp_r = e_big - shift;
    end
    res = zero ? '0 : {big[DATA_SIZE-1], exp_r, frac};
  end

  assign unused_bits = ^norm[FW+1:FW];

  always_ff @(posedge CLK) begin
    if (RST) begin
      READY    <= 1'b0;
      DATA_OUT <= '0;
    end else begin
      READY <= START;
      if (START) DATA_OUT <= res;
    end
  end
endmodule

// state      | meaning
// IDLE       | wait for START, validate sizes
// LOAD       | accept A/B strobes until both counts are full
// MULTIPLY   | one term: integer MAC, or float multiplier handshake
// ACCUMULATE | float adder handshake folding the product into acc
// EMIT       | present y[k] for one cycle, step to next k
// DONE       | READY pulse (ERROR when sizes were rejected)
module accelerator_convolution_engine #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int MAX_LENGTH   = 16,
  parameter int FLOAT        = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  output logic                 ERROR,
  input  logic [DATA_SIZE-1:0] SIZE_A_IN,
  input  logic [DATA_SIZE-1:0] SIZE_B_IN,
  input  logic                 DATA_A_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] DATA_A_IN,
  input  logic                 DATA_B_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] DATA_B_IN,
  output logic                 DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] DATA_OUT
);
  localparam int CW = $clog2(2 * MAX_LENGTH + 1);
  localparam int AW = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
  localparam logic [DATA_SIZE-1:0] MAX_LEN_D = DATA_SIZE'(MAX_LENGTH);

  typedef enum logic [2:0] {IDLE, LOAD, MULTIPLY, ACCUMULATE, EMIT, DONE} state_t;
  state_t state, state_nxt;

  logic [DATA_SIZE-1:0] buf_a [MAX_LENGTH];
  logic [DATA_SIZE-1:0] buf_b [MAX_LENGTH];
  logic [CW-1:0]        n_len, m_len, cnt_a, cnt_b, k, j;
  logic [CW-1:0]        j_lo, j_lo_next, j_hi, last_k;
  logic [AW-1:0]        a_idx;
  logic [DATA_SIZE-1:0] acc, prod, data_out_q, term_a, term_b, prod_int, acc_sum;
  logic [DATA_SIZE-1:0] mul_out, add_out;
  logic                 mul_start, add_start, mul_ready, add_ready;
  logic                 busy, err, sizes_ok, load_done, first_term, last_term;

  assign sizes_ok  = (SIZE_A_IN != '0) && (SIZE_A_IN <= MAX_LEN_D) &&
                     (SIZE_B_IN != '0) && (SIZE_B_IN <= MAX_LEN_D);
  assign load_done = (cnt_a == n_len) && (cnt_b == m_len);
  assign last_k    = n_len + m_len - CW'(2);
  // In-range terms for output k run j = max(0, k-N+1) .. min(k, M-1).
  assign j_lo      = (k >= n_len) ? k - n_len + CW'(1) : '0;
  assign j_lo_next = (k + CW'(1) >= n_len) ? k + CW'(2) - n_len : '0;
  assign j_hi      = (k < m_len) ? k : m_len - CW'(1);
  assign first_term = (j == j_lo);
  assign last_term  = (j == j_hi);
  assign a_idx     = AW'(k - j);
  assign term_a    = buf_a[a_idx];
  assign term_b    = buf_b[j[AW-1:0]];
  assign prod_int  = term_a * term_b;
  assign acc_sum   = (first_term ? '0 : acc) + prod_int;

  generate
    if (FLOAT != 0) begin : g_float
      accelerator_scalar_float_multiplier #(.DATA_SIZE(DATA_SIZE), .CONTROL_SIZE(CONTROL_SIZE)) u_mul (
        .CLK(CLK), .RST(RST), .START(mul_start), .OPERATION('0),
        .DATA_A_IN(term_a), .DATA_B_IN(term_b), .READY(mul_ready), .DATA_OUT(mul_out));
      accelerator_scalar_float_adder #(.DATA_SIZE(DATA_SIZE), .CONTROL_SIZE(CONTROL_SIZE)) u_add (
        .CLK(CLK), .RST(RST), .START(add_start), .OPERATION('0),
        .DATA_A_IN(acc), .DATA_B_IN(prod), .READY(add_ready), .DATA_OUT(add_out));
    end else begin : g_int
      assign mul_ready = 1'b0;
      assign add_ready = 1'b0;
      assign mul_out   = '0;
      assign add_out   = '0;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    add_start = 1'b0;
    case (state)
      IDLE:     if (START) state_nxt = sizes_ok ? LOAD : DONE;
      LOAD:     if (load_done) state_nxt = MULTIPLY;
      MULTIPLY: begin
        if (FLOAT == 0) begin
          if (last_term) state_nxt = EMIT;
        end else if (!busy) begin
          mul_start = 1'b1;
        end else if (mul_ready) begin
          if (!first_term)    state_nxt = ACCUMULATE;
          else if (last_term) state_nxt = EMIT;
        end
      end
      ACCUMULATE: begin
        if (!busy)          add_start = 1'b1;
        else if (add_ready) state_nxt = last_term ? EMIT : MULTIPLY;
      end
      EMIT:    state_nxt = (k == last_k) ? DONE : MULTIPLY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (RST) begin
      mul_start = 1'b0;
      add_start = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      busy       <= 1'b0;
      err        <= 1'b0;
      n_len      <= '0;
      m_len      <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      k          <= '0;
      j          <= '0;
      acc        <= '0;
      prod       <= '0;
      data_out_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (START) begin
          n_len <= SIZE_A_IN[CW-1:0];
          m_len <= SIZE_B_IN[CW-1:0];
          cnt_a <= '0;
          cnt_b <= '0;
          err   <= !sizes_ok;
        end
        LOAD: begin
          if (DATA_A_IN_ENABLE && cnt_a < n_len) cnt_a <= cnt_a + CW'(1);
          if (DATA_B_IN_ENABLE && cnt_b < m_len) cnt_b <= cnt_b + CW'(1);
          if (load_done) begin
            k <= '0;
            j <= '0;
          end
        end
        MULTIPLY: begin
          if (FLOAT == 0) begin
            acc <= acc_sum;
            if (last_term) data_out_q <= acc_sum;
            else           j <= j + CW'(1);
          end else if (!busy) begin
            busy <= 1'b1;
          end else if (mul_ready) begin
            busy <= 1'b0;
            if (first_term) begin
              acc <= mul_out;
              if (last_term) data_out_q <= mul_out;
              else           j <= j + CW'(1);
            end else begin
              prod <= mul_out;
            end
          end
        end
        ACCUMULATE: begin
          if (!busy) begin
            busy <= 1'b1;
          end else if (add_ready) begin
            busy <= 1'b0;
            acc  <= add_out;
            if (last_term) data_out_q <= add_out;
            else           j <= j + CW'(1);
          end
        end
        EMIT: begin
          k <= k + CW'(1);
          j <= j_lo_next;
        end
        default: ;
      endcase
    end
  end

  // Buffers are never cleared; only the slots written in LOAD are ever read.
  always_ff @(posedge CLK) begin
    if (!RST && state == LOAD) begin
      if (DATA_A_IN_ENABLE && cnt_a < n_len) buf_a[cnt_a[AW-1:0]] <= DATA_A_IN;
      if (DATA_B_IN_ENABLE && cnt_b < m_len) buf_b[cnt_b[AW-1:0]] <= DATA_B_IN;
    end
  end

  assign READY           = !RST && (state == DONE);
  assign ERROR           = !RST && (state == DONE) && err;
  assign DATA_OUT_ENABLE = !RST && (state == EMIT);
  assign DATA_OUT        = RST ? '0 : data_out_q;
endmodule

// File: tb/tb_accelerator_convolution_engine.sv
// Scoreboard bench: integer and float engines side by side, expected outputs queued at stimulus time.
module tb_accelerator_convolution_engine;
  logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0, start_f = 1'b0;
  logic [63:0] size_a = '0, size_b = '0, a_data = '0, b_data = '0;
  logic        a_en = 1'b0, b_en = 1'b0;
  logic        rdy_i, err_i, oen_i, rdy_f, err_f, oen_f;
  logic [63:0] dout_i, dout_f;

  int          checks = 0, errors = 0;
  int          rdy_cnt_i = 0, rdy_cnt_f = 0;
  logic        last_err_i = 1'b0, last_err_f = 1'b0;
  logic [63:0] exp_i[$], exp_f[$];
  logic [63:0] va [16], vb [16];

  accelerator_convolution_engine #(.DATA_SIZE(64), .CONTROL_SIZE(64), .MAX_LENGTH(16), .FLOAT(0)) u_int (
    .CLK(clk), .RST(rst), .START(start_i), .READY(rdy_i), .ERROR(err_i),
    .SIZE_A_IN(size_a), .SIZE_B_IN(size_b),
    .DATA_A_IN_ENABLE(a_en), .DATA_A_IN(a_data), .DATA_B_IN_ENABLE(b_en), .DATA_B_IN(b_data),
    .DATA_OUT_ENABLE(oen_i), .DATA_OUT(dout_i));

  accelerator_convolution_engine #(.DATA_SIZE(64), .CONTROL_SIZE(64), .MAX_LENGTH(16), .FLOAT(1)) u_flt (
    .CLK(clk), .RST(rst), .START(start_f), .READY(rdy_f), .ERROR(err_f),
    .SIZE_A_IN(size_a), .SIZE_B_IN(size_b),
    .DATA_A_IN_ENABLE(a_en), .DATA_A_IN(a_data), .DATA_B_IN_ENABLE(b_en), .DATA_B_IN(b_data),
    .DATA_OUT_ENABLE(oen_f), .DATA_OUT(dout_f));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [63:0] e;
    if (oen_i) begin
      checks++;
      if (exp_i.size() == 0) begin
        errors++;
        $display("FAIL out_int unexpected output got %h", dout_i);
      end else begin
        e = exp_i.pop_front();
        if (dout_i !== e) begin
          errors++;
          $display("FAIL out_int got %h expected %h", dout_i, e);
        end
      end
    end
    if (oen_f) begin
      checks++;
      if (exp_f.size() == 0) begin
        errors++;
        $display("FAIL out_flt unexpected output got %h", dout_f);
      end else begin
        e = exp_f.pop_front();
        if (dout_f !== e) begin
          errors++;
          $display("FAIL out_flt got %h expected %h", dout_f, e);
        end
      end
    end
    if (rdy_i) begin rdy_cnt_i++; last_err_i = err_i; end
    if (rdy_f) begin rdy_cnt_f++; last_err_f = err_f; end
  end

  function automatic logic [63:0] model_int(input int n, input int m, input int k);
    logic [63:0] s = '0;
    for (int jj = 0; jj < m; jj++)
      if (k - jj >= 0 && k - jj < n) s = s + va[k - jj] * vb[jj];
    return s;
  endfunction

  task automatic push_int(input int n, input int m);
    for (int kk = 0; kk <= n + m - 2; kk++) exp_i.push_back(model_int(n, m, kk));
  endtask

  task automatic start_op(input bit flt, input int n, input int m);
    @(posedge clk); #1;
    size_a = 64'(n);
    size_b = 64'(m);
    if (flt) start_f = 1'b1; else start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    start_f = 1'b0;
  endtask

  task automatic load_ops(input int n, input int m, input bit same);
    if (same) begin
      for (int i = 0; i < ((n > m) ? n : m); i++) begin
        a_en = (i < n); b_en = (i < m); a_data = va[i]; b_data = vb[i];
        @(posedge clk); #1;
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        a_en = 1'b1; a_data = va[i];
        @(posedge clk); #1;
      end
      a_en = 1'b0;
      for (int i = 0; i < m; i++) begin
        b_en = 1'b1; b_data = vb[i];
        @(posedge clk); #1;
      end
    end
    a_en = 1'b0;
    b_en = 1'b0;
  endtask

  task automatic wait_done(input bit flt, input int base, input bit exp_err, input string name);
    int c = 0;
    while (((flt ? rdy_cnt_f : rdy_cnt_i) == base) && c < 1500) begin
      @(negedge clk); #1;
      c++;
    end
    checks++;
    if ((flt ? rdy_cnt_f : rdy_cnt_i) == base) begin
      errors++;
      $display("FAIL %s ready timeout got none required one pulse", name);
    end else begin
      checks++;
      if ((flt ? last_err_f : last_err_i) !== exp_err) begin
        errors++;
        $display("FAIL %s error flag got %b required %b", name, flt ? last_err_f : last_err_i, exp_err);
      end
      @(negedge clk);
      checks++;
      if ((flt ? rdy_f : rdy_i) !== 1'b0) begin
        errors++;
        $display("FAIL %s ready pulse width got high on second cycle required low", name);
      end
    end
    checks++;
    if ((flt ? exp_f.size() : exp_i.size()) != 0) begin
      errors++;
      $display("FAIL %s outputs missing got %0d left required 0", name, flt ? exp_f.size() : exp_i.size());
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if ({rdy_i, err_i, oen_i, rdy_f, err_f, oen_f} !== 6'b0 || dout_i !== '0 || dout_f !== '0) begin
      errors++;
      $display("FAIL %s outputs in reset got %b %h %h required zeros", name,
               {rdy_i, err_i, oen_i, rdy_f, err_f, oen_f}, dout_i, dout_f);
    end
  endtask

  task automatic run_basic(input string name);
    int base = rdy_cnt_i;
    va[0] = 64'd1; va[1] = 64'd2; va[2] = 64'd3;
    vb[0] = 64'd1; vb[1] = 64'd1;
    push_int(3, 2);
    start_op(1'b0, 3, 2);
    load_ops(3, 2, 1'b0);
    wait_done(1'b0, base, 1'b0, name);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_same_cycle();
    int base = rdy_cnt_i;
    va[0] = 64'd2; va[1] = 64'd3;
    vb[0] = 64'd4; vb[1] = 64'd5;
    exp_i.push_back(64'd8);
    exp_i.push_back(64'd22);
    exp_i.push_back(64'd15);
    start_op(1'b0, 2, 2);
    load_ops(2, 2, 1'b1);
    a_en = 1'b1; b_en = 1'b1; a_data = 64'd100; b_data = 64'd100;
    @(posedge clk); #1;
    a_en = 1'b0; b_en = 1'b0;
    wait_done(1'b0, base, 1'b0, "same_cycle");
  endtask

  task automatic test_wrap();
    int base = rdy_cnt_i;
    va[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    vb[0] = 64'd2;
    exp_i.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    start_op(1'b0, 1, 1);
    load_ops(1, 1, 1'b0);
    wait_done(1'b0, base, 1'b0, "wrap");
  endtask

  task automatic test_error();
    int base = rdy_cnt_i;
    start_op(1'b0, 0, 2);
    wait_done(1'b0, base, 1'b1, "err_size_a_zero");
    base = rdy_cnt_i;
    start_op(1'b0, 2, 17);
    wait_done(1'b0, base, 1'b1, "err_size_b_max");
  endtask

  task automatic test_float();
    int base = rdy_cnt_f;
    va[0] = 64'h3FF0_0000_0000_0000; va[1] = 64'h4000_0000_0000_0000;
    vb[0] = 64'h3FE0_0000_0000_0000;
    exp_f.push_back(64'h3FE0_0000_0000_0000);
    exp_f.push_back(64'h3FF0_0000_0000_0000);
    start_op(1'b1, 2, 1);
    load_ops(2, 1, 1'b0);
    wait_done(1'b1, base, 1'b0, "float_scale");
    base = rdy_cnt_f;
    vb[0] = 64'h3FF0_0000_0000_0000; vb[1] = 64'hBFE0_0000_0000_0000;
    exp_f.push_back(64'h3FF0_0000_0000_0000);
    exp_f.push_back(64'h3FF8_0000_0000_0000);
    exp_f.push_back(64'hBFF0_0000_0000_0000);
    start_op(1'b1, 2, 2);
    load_ops(2, 2, 1'b1);
    wait_done(1'b1, base, 1'b0, "float_accumulate");
  endtask

  task automatic test_reset_abort();
    int base = rdy_cnt_i;
    bit seen = 1'b0;
    va[0] = 64'd1; va[1] = 64'd2; va[2] = 64'd3;
    vb[0] = 64'd1; vb[1] = 64'd1;
    push_int(3, 2);
    start_op(1'b0, 3, 2);
    load_ops(3, 2, 1'b0);
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (oen_i) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL abort first output timeout got none required one");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_i.delete();
    @(negedge clk);
    check_quiet("abort_in_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (rdy_cnt_i != base) begin
      errors++;
      $display("FAIL abort ready after reset got %0d pulses required 0", rdy_cnt_i - base);
    end
    run_basic("restart_after_abort");
  endtask

  task automatic test_back_to_back();
    int base = rdy_cnt_i;
    for (int i = 0; i < 16; i++) begin
      va[i] = {$urandom, $urandom};
      vb[i] = {$urandom, $urandom};
    end
    push_int(16, 16);
    start_op(1'b0, 16, 16);
    load_ops(16, 16, 1'b1);
    wait_done(1'b0, base, 1'b0, "max_length");
    run_basic("back_to_back");
  endtask

  initial begin
    test_reset();
    run_basic("basic");
    test_same_cycle();
    test_wrap();
    test_error();
    test_float();
    test_reset_abort();
    test_back_to_back();
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
